// File: rtl/gmem_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gmem_rd_arbiter
// Description : Shares the kernel's single m_axi_gmem read channel (AR + R)
//               between NUM_REQ internal requesters. Round-robin grant, one
//               burst outstanding at a time. R beats are routed back to the
//               burst owner; beat count and RRESP are checked and any
//               protocol problem raises a sticky error flag.
// Ports       : ap_clk / ap_rst        clock, async active-high reset
//               req_ar*                per-requester burst request / accept
//               req_r*                 beat delivery to the burst owner
//               m_axi_gmem_AR* / R*    kernel master read channel
//               busy / owner           status: not idle / current-last grant
//               err / err_clear        sticky protocol error and its clear
// Revision    : 1.0 - initial release
// ============================================================================
module gmem_rd_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 1
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic [NUM_REQ-1:0]            req_arvalid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
    input  logic [NUM_REQ*8-1:0]          req_arlen,
    output logic [NUM_REQ-1:0]            req_arready,
    output logic [NUM_REQ-1:0]            req_rvalid,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic                          req_rlast,
    output logic [1:0]                    req_rresp,
    input  logic [NUM_REQ-1:0]            req_rready,
    output logic                          m_axi_gmem_ARVALID,
    output logic [ADDR_WIDTH-1:0]         m_axi_gmem_ARADDR,
    output logic [ID_WIDTH-1:0]           m_axi_gmem_ARID,
    output logic [7:0]                    m_axi_gmem_ARLEN,
    output logic [2:0]                    m_axi_gmem_ARSIZE,
    output logic [1:0]                    m_axi_gmem_ARBURST,
    input  logic                          m_axi_gmem_ARREADY,
    input  logic                          m_axi_gmem_RVALID,
    input  logic [DATA_WIDTH-1:0]         m_axi_gmem_RDATA,
    input  logic                          m_axi_gmem_RLAST,
    input  logic [1:0]                    m_axi_gmem_RRESP,
    output logic                          m_axi_gmem_RREADY,
    output logic                          busy,
    output logic [2:0]                    owner,
    output logic                          err,
    input  logic                          err_clear
);

    localparam int             c_IDX_W  = $clog2(NUM_REQ);
    localparam logic [2:0]     c_ARSIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_IDX_W-1:0]      r_rr_ptr;
    logic [c_IDX_W-1:0]      r_owner;
    logic [8:0]              r_beat_cnt;
    logic                    r_err;
    logic                    r_arvalid;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic [7:0]              r_arlen;

    logic                    w_found;
    logic [c_IDX_W-1:0]      w_winner;
    logic [c_IDX_W:0]        w_sum;
    logic                    w_grant;
    logic                    w_ar_hs;
    logic                    w_in_data;
    logic                    w_r_hs;
    logic                    w_last_hs;
    logic                    w_err_set;

    // Round-robin scan starting at r_rr_ptr. Iterating downward means the
    // lowest offset (closest to the pointer) is the last one written and wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (c_IDX_W+1)'(k);
            if (w_sum >= (c_IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (c_IDX_W+1)'(NUM_REQ);
            end
            if (req_arvalid[w_sum[c_IDX_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[c_IDX_W-1:0];
            end
        end
    end

    // The reset term keeps the combinational grant quiet while ap_rst is held.
    assign w_grant   = (r_state == S_IDLE) && w_found && !ap_rst;
    assign w_ar_hs   = r_arvalid && m_axi_gmem_ARREADY;
    assign w_in_data = (r_state == S_DATA);
    assign w_r_hs    = m_axi_gmem_RVALID && m_axi_gmem_RREADY;
    assign w_last_hs = w_r_hs && m_axi_gmem_RLAST;

    // r_beat_cnt holds the number of beats already taken, so the beat being
    // accepted now has index r_beat_cnt. A last beat must have index ARLEN;
    // a non-last beat at index ARLEN is one beat too many.
    assign w_err_set = w_r_hs &&
                       ((m_axi_gmem_RRESP != 2'b00) ||
                        (m_axi_gmem_RLAST  && (r_beat_cnt != {1'b0, r_arlen})) ||
                        (!m_axi_gmem_RLAST && (r_beat_cnt == {1'b0, r_arlen})));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant)   w_state_next = S_ADDR;
            S_ADDR:  if (w_ar_hs)   w_state_next = S_DATA;
            S_DATA:  if (w_last_hs) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_arready = '0;
        req_rvalid  = '0;
        if (w_grant) begin
            req_arready[w_winner] = 1'b1;
        end
        if (w_in_data) begin
            req_rvalid[r_owner] = m_axi_gmem_RVALID;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
            r_arvalid  <= 1'b0;
            r_araddr   <= '0;
            r_arlen    <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_grant) begin
                r_araddr   <= req_araddr[w_winner*ADDR_WIDTH +: ADDR_WIDTH];
                r_arlen    <= req_arlen[w_winner*8 +: 8];
                r_owner    <= w_winner;
                r_beat_cnt <= '0;
                r_arvalid  <= 1'b1;
            end else if (w_ar_hs) begin
                r_arvalid  <= 1'b0;
            end

            // Saturate so a runaway burst cannot wrap back to a "legal" count.
            if (w_r_hs && (r_beat_cnt != '1)) begin
                r_beat_cnt <= r_beat_cnt + 9'd1;
            end

            if (w_last_hs) begin
                r_rr_ptr <= (r_owner == c_IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
            end

            // A new error in the same cycle as err_clear takes priority.
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clear) begin
                r_err <= 1'b0;
            end
        end
    end

    assign m_axi_gmem_ARVALID = r_arvalid;
    assign m_axi_gmem_ARADDR  = r_araddr;
    assign m_axi_gmem_ARID    = '0;
    assign m_axi_gmem_ARLEN   = r_arlen;
    assign m_axi_gmem_ARSIZE  = c_ARSIZE;
    assign m_axi_gmem_ARBURST = 2'b01;
    assign m_axi_gmem_RREADY  = w_in_data && req_rready[r_owner];

    assign req_rdata = m_axi_gmem_RDATA;
    assign req_rlast = m_axi_gmem_RLAST;
    assign req_rresp = m_axi_gmem_RRESP;

    assign busy  = (r_state != S_IDLE);
    assign owner = 3'(r_owner);
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gmem_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gmem_rd_arbiter
// Description : Directed self-checking bench for gmem_rd_arbiter: single
//               burst, round-robin contention, R backpressure, beat-count
//               mismatch, SLVERR with err_clear priority, async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gmem_rd_arbiter;

    localparam int N  = 2;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 1;

    logic            ap_clk = 1'b0;
    logic            ap_rst;
    logic [N-1:0]    req_arvalid;
    logic [N*AW-1:0] req_araddr;
    logic [N*8-1:0]  req_arlen;
    logic [N-1:0]    req_arready;
    logic [N-1:0]    req_rvalid;
    logic [DW-1:0]   req_rdata;
    logic            req_rlast;
    logic [1:0]      req_rresp;
    logic [N-1:0]    req_rready;
    logic            m_axi_gmem_ARVALID;
    logic [AW-1:0]   m_axi_gmem_ARADDR;
    logic [IW-1:0]   m_axi_gmem_ARID;
    logic [7:0]      m_axi_gmem_ARLEN;
    logic [2:0]      m_axi_gmem_ARSIZE;
    logic [1:0]      m_axi_gmem_ARBURST;
    logic            m_axi_gmem_ARREADY;
    logic            m_axi_gmem_RVALID;
    logic [DW-1:0]   m_axi_gmem_RDATA;
    logic            m_axi_gmem_RLAST;
    logic [1:0]      m_axi_gmem_RRESP;
    logic            m_axi_gmem_RREADY;
    logic            busy;
    logic [2:0]      owner;
    logic            err;
    logic            err_clear;

    int checks = 0;
    int errors = 0;

    always #5 ap_clk = ~ap_clk;

    gmem_rd_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW)
    ) u_dut (
        .ap_clk             (ap_clk),
        .ap_rst             (ap_rst),
        .req_arvalid        (req_arvalid),
        .req_araddr         (req_araddr),
        .req_arlen          (req_arlen),
        .req_arready        (req_arready),
        .req_rvalid         (req_rvalid),
        .req_rdata          (req_rdata),
        .req_rlast          (req_rlast),
        .req_rresp          (req_rresp),
        .req_rready         (req_rready),
        .m_axi_gmem_ARVALID (m_axi_gmem_ARVALID),
        .m_axi_gmem_ARADDR  (m_axi_gmem_ARADDR),
        .m_axi_gmem_ARID    (m_axi_gmem_ARID),
        .m_axi_gmem_ARLEN   (m_axi_gmem_ARLEN),
        .m_axi_gmem_ARSIZE  (m_axi_gmem_ARSIZE),
        .m_axi_gmem_ARBURST (m_axi_gmem_ARBURST),
        .m_axi_gmem_ARREADY (m_axi_gmem_ARREADY),
        .m_axi_gmem_RVALID  (m_axi_gmem_RVALID),
        .m_axi_gmem_RDATA   (m_axi_gmem_RDATA),
        .m_axi_gmem_RLAST   (m_axi_gmem_RLAST),
        .m_axi_gmem_RRESP   (m_axi_gmem_RRESP),
        .m_axi_gmem_RREADY  (m_axi_gmem_RREADY),
        .busy               (busy),
        .owner              (owner),
        .err                (err),
        .err_clear          (err_clear)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Grant in IDLE, then AR handshake. Ends in DATA at posedge+1.
    task automatic ar_grant(input logic [N-1:0] reqs, input int win, input logic [63:0] addr,
                            input logic [7:0] len, input bit hold, input string tag);
        logic [N-1:0] exp_oh;
        exp_oh = '0;
        exp_oh[win] = 1'b1;
        req_arvalid = reqs;
        #1;
        check_val({tag, " arready"}, 64'(req_arready), 64'(exp_oh));
        check_val({tag, " idle busy"}, 64'(busy), 64'd0);
        check_val({tag, " idle arvalid"}, 64'(m_axi_gmem_ARVALID), 64'd0);
        step();
        req_arvalid = hold ? reqs : '0;
        #1;
        check_val({tag, " arvalid"}, 64'(m_axi_gmem_ARVALID), 64'd1);
        check_val({tag, " araddr"}, m_axi_gmem_ARADDR, addr);
        check_val({tag, " arlen"}, 64'(m_axi_gmem_ARLEN), 64'(len));
        check_val({tag, " owner"}, 64'(owner), 64'(win));
        check_val({tag, " busy"}, 64'(busy), 64'd1);
        check_val({tag, " no regrant"}, 64'(req_arready), 64'd0);
        m_axi_gmem_ARREADY = 1'b1;
        step();
        m_axi_gmem_ARREADY = 1'b0;
        check_val({tag, " arvalid drop"}, 64'(m_axi_gmem_ARVALID), 64'd0);
    endtask

    // One accepted R beat (owner's rready must already be high).
    task automatic beat(input logic [63:0] data, input logic last, input logic [1:0] resp,
                        input logic [N-1:0] exp_rv, input string tag);
        m_axi_gmem_RVALID = 1'b1;
        m_axi_gmem_RDATA  = data;
        m_axi_gmem_RLAST  = last;
        m_axi_gmem_RRESP  = resp;
        #1;
        check_val({tag, " rvalid"}, 64'(req_rvalid), 64'(exp_rv));
        check_val({tag, " rdata"}, req_rdata, data);
        check_val({tag, " rlast"}, 64'(req_rlast), 64'(last));
        check_val({tag, " rresp"}, 64'(req_rresp), 64'(resp));
        check_val({tag, " rready"}, 64'(m_axi_gmem_RREADY), 64'd1);
        step();
        m_axi_gmem_RVALID = 1'b0;
        m_axi_gmem_RLAST  = 1'b0;
        m_axi_gmem_RRESP  = 2'b00;
    endtask

    initial begin
        ap_rst             = 1'b1;
        req_arvalid        = 2'b01;
        req_araddr         = '0;
        req_arlen          = '0;
        req_rready         = '0;
        m_axi_gmem_ARREADY = 1'b0;
        m_axi_gmem_RVALID  = 1'b0;
        m_axi_gmem_RDATA   = '0;
        m_axi_gmem_RLAST   = 1'b0;
        m_axi_gmem_RRESP   = 2'b00;
        err_clear          = 1'b0;

        // Reset state
        repeat (2) @(posedge ap_clk);
        #1;
        check_val("rst busy", 64'(busy), 64'd0);
        check_val("rst arvalid", 64'(m_axi_gmem_ARVALID), 64'd0);
        check_val("rst araddr", m_axi_gmem_ARADDR, 64'd0);
        check_val("rst arlen", 64'(m_axi_gmem_ARLEN), 64'd0);
        check_val("rst rready", 64'(m_axi_gmem_RREADY), 64'd0);
        check_val("rst req_arready", 64'(req_arready), 64'd0);
        check_val("rst req_rvalid", 64'(req_rvalid), 64'd0);
        check_val("rst owner", 64'(owner), 64'd0);
        check_val("rst err", 64'(err), 64'd0);
        check_val("arsize", 64'(m_axi_gmem_ARSIZE), 64'd3);
        check_val("arburst", 64'(m_axi_gmem_ARBURST), 64'd1);
        check_val("arid", 64'(m_axi_gmem_ARID), 64'd0);
        req_arvalid = '0;
        ap_rst      = 1'b0;
        step();

        // 1: single 4-beat burst from requester 0
        req_araddr[63:0] = 64'h1000;
        req_arlen[7:0]   = 8'd3;
        req_rready       = 2'b01;
        ar_grant(2'b01, 0, 64'h1000, 8'd3, 1'b0, "t1");
        for (int k = 0; k < 4; k++) begin
            beat(64'hD0 + 64'(k), (k == 3), 2'b00, 2'b01, "t1 beat");
        end
        check_val("t1 busy end", 64'(busy), 64'd0);
        check_val("t1 err", 64'(err), 64'd0);

        // 2: contention, both held; rr_ptr is 1 after t1 so grants go 1,0,1,0
        req_araddr = {64'h3000, 64'h2000};
        req_arlen  = '0;
        req_rready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            int w;
            w = (i + 1) % 2;
            ar_grant(2'b11, w, (w == 1) ? 64'h3000 : 64'h2000, 8'd0, 1'b1, "t2");
            beat(64'h100 + 64'(i), 1'b1, 2'b00, (w == 1) ? 2'b10 : 2'b01, "t2 beat");
        end
        req_arvalid = '0;
        check_val("t2 err", 64'(err), 64'd0);

        // 3: backpressure on a 2-beat burst
        req_araddr[63:0] = 64'h4000;
        req_arlen[7:0]   = 8'd1;
        ar_grant(2'b01, 0, 64'h4000, 8'd1, 1'b0, "t3");
        m_axi_gmem_RVALID = 1'b1;
        m_axi_gmem_RDATA  = 64'hA0;
        m_axi_gmem_RLAST  = 1'b0;
        req_rready        = 2'b00;
        #1;
        check_val("t3 stall0 rready", 64'(m_axi_gmem_RREADY), 64'd0);
        check_val("t3 stall0 rvalid", 64'(req_rvalid), 64'd1);
        check_val("t3 stall0 rdata", req_rdata, 64'hA0);
        step();
        req_rready = 2'b01;
        #1;
        check_val("t3 go0 rready", 64'(m_axi_gmem_RREADY), 64'd1);
        check_val("t3 go0 rdata", req_rdata, 64'hA0);
        step();
        m_axi_gmem_RDATA = 64'hA1;
        m_axi_gmem_RLAST = 1'b1;
        req_rready       = 2'b00;
        #1;
        check_val("t3 stall1 rready", 64'(m_axi_gmem_RREADY), 64'd0);
        check_val("t3 stall1 busy", 64'(busy), 64'd1);
        step();
        check_val("t3 held busy", 64'(busy), 64'd1);
        req_rready = 2'b01;
        #1;
        check_val("t3 go1 rready", 64'(m_axi_gmem_RREADY), 64'd1);
        check_val("t3 go1 rdata", req_rdata, 64'hA1);
        step();
        m_axi_gmem_RVALID = 1'b0;
        m_axi_gmem_RLAST  = 1'b0;
        check_val("t3 busy end", 64'(busy), 64'd0);
        check_val("t3 err", 64'(err), 64'd0);

        // 4: ARLEN=3 but RLAST on the second beat
        req_araddr[63:0] = 64'h5000;
        req_arlen[7:0]   = 8'd3;
        ar_grant(2'b01, 0, 64'h5000, 8'd3, 1'b0, "t4");
        beat(64'hB0, 1'b0, 2'b00, 2'b01, "t4 b0");
        check_val("t4 err mid", 64'(err), 64'd0);
        beat(64'hB1, 1'b1, 2'b00, 2'b01, "t4 b1");
        check_val("t4 err set", 64'(err), 64'd1);
        check_val("t4 idle", 64'(busy), 64'd0);
        err_clear = 1'b1;
        #1;
        check_val("t4 err before edge", 64'(err), 64'd1);
        step();
        err_clear = 1'b0;
        check_val("t4 err cleared", 64'(err), 64'd0);

        // 5: SLVERR on requester 1, err_clear in the same cycle loses
        req_araddr[127:64] = 64'h6000;
        req_arlen[15:8]    = 8'd1;
        req_rready         = 2'b10;
        ar_grant(2'b10, 1, 64'h6000, 8'd1, 1'b0, "t5");
        err_clear = 1'b1;
        beat(64'hC0, 1'b0, 2'b10, 2'b10, "t5 b0");
        err_clear = 1'b0;
        check_val("t5 err set wins", 64'(err), 64'd1);
        check_val("t5 busy mid", 64'(busy), 64'd1);
        beat(64'hC1, 1'b1, 2'b00, 2'b10, "t5 b1");
        check_val("t5 busy end", 64'(busy), 64'd0);
        check_val("t5 owner", 64'(owner), 64'd1);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check_val("t5 err cleared", 64'(err), 64'd0);

        // 6: move rr_ptr to 1, then async reset in the middle of a burst
        req_araddr[63:0] = 64'h7000;
        req_arlen[7:0]   = 8'd0;
        req_rready       = 2'b01;
        ar_grant(2'b01, 0, 64'h7000, 8'd0, 1'b0, "t6a");
        beat(64'hF0, 1'b1, 2'b00, 2'b01, "t6a b0");
        req_araddr[127:64] = 64'h8000;
        req_arlen[15:8]    = 8'd3;
        req_rready         = 2'b10;
        ar_grant(2'b10, 1, 64'h8000, 8'd3, 1'b0, "t6");
        beat(64'hE0, 1'b0, 2'b10, 2'b10, "t6 b0");
        check_val("t6 err pre", 64'(err), 64'd1);
        beat(64'hE1, 1'b0, 2'b00, 2'b10, "t6 b1");
        m_axi_gmem_RVALID = 1'b1;
        m_axi_gmem_RDATA  = 64'hE2;
        req_arvalid       = 2'b11;
        #2;
        ap_rst = 1'b1;
        #1;
        check_val("t6 rst busy", 64'(busy), 64'd0);
        check_val("t6 rst arvalid", 64'(m_axi_gmem_ARVALID), 64'd0);
        check_val("t6 rst araddr", m_axi_gmem_ARADDR, 64'd0);
        check_val("t6 rst arlen", 64'(m_axi_gmem_ARLEN), 64'd0);
        check_val("t6 rst rready", 64'(m_axi_gmem_RREADY), 64'd0);
        check_val("t6 rst req_rvalid", 64'(req_rvalid), 64'd0);
        check_val("t6 rst req_arready", 64'(req_arready), 64'd0);
        check_val("t6 rst owner", 64'(owner), 64'd0);
        check_val("t6 rst err", 64'(err), 64'd0);
        m_axi_gmem_RVALID = 1'b0;
        step();
        step();
        ap_rst = 1'b0;
        #1;
        check_val("t6 post arready", 64'(req_arready), 64'd1);
        step();
        req_arvalid = '0;
        check_val("t6 post owner", 64'(owner), 64'd0);
        check_val("t6 post arvalid", 64'(m_axi_gmem_ARVALID), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
